// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 500000;
  localparam int DEF_REPEAT_PERIOD   = 100000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, counter debounce, edge pulses and
// hold-to-repeat sequencer.
module btn_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
  localparam bit            RPT_ON      = (REPEAT_DELAY > 0);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   differ_s, flip_s, rise_s, fall_s;
  logic                   press_r, release_r, repeat_r;
  rpt_state_t             state_r, state_s;
  logic [RW-1:0]          rcnt_r, rcnt_s;
  logic                   repeat_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Metastability chain for the asynchronous pad level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sync_r <= {SYNC_STAGES{1'b0}};
    else       sync_r <= {sync_r[SYNC_STAGES-2:0], btn_raw};
  end

  // Level flips on the edge that completes DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    differ_s = (sync_s != level_r);
    flip_s   = differ_s && (cnt_r == CNT_LAST);
    rise_s   = flip_s && !level_r;
    fall_s   = flip_s && level_r;
  end

  // Debounce counter and debounced level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else begin
      if (!differ_s || flip_s) cnt_r <= {CW{1'b0}};
      else                     cnt_r <= cnt_r + CW'(1);
      if (flip_s) level_r <= !level_r;
    end
  end

  // Repeat sequencer next state; leaving on released level or disabled events.
  always_comb begin
    state_s  = state_r;
    rcnt_s   = rcnt_r;
    repeat_s = 1'b0;
    case (state_r)
      RPT_IDLE: begin
        if (RPT_ON && rise_s && en) begin
          state_s = RPT_DELAY;
          rcnt_s  = DELAY_LOAD;
        end else begin
          state_s = RPT_IDLE;
          rcnt_s  = rcnt_r;
        end
      end
      RPT_DELAY, RPT_REPEAT: begin
        if (!level_r || !en) begin
          state_s = RPT_IDLE;
          rcnt_s  = {RW{1'b0}};
        end else if (rcnt_r == {RW{1'b0}}) begin
          state_s  = RPT_REPEAT;
          rcnt_s   = PERIOD_LOAD;
          repeat_s = 1'b1;
        end else begin
          state_s = state_r;
          rcnt_s  = rcnt_r - RW'(1);
        end
      end
      default: begin
        state_s = RPT_IDLE;
        rcnt_s  = {RW{1'b0}};
      end
    endcase
  end

  // Registered event pulses and sequencer state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      repeat_r  <= 1'b0;
      state_r   <= RPT_IDLE;
      rcnt_r    <= {RW{1'b0}};
    end else begin
      press_r   <= en && rise_s;
      release_r <= en && fall_s;
      repeat_r  <= repeat_s;
      state_r   <= state_s;
      rcnt_r    <= rcnt_s;
    end
  end

  assign btn_level     = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign repeat_pulse  = repeat_r;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel button front end: independent per-channel conditioners plus
// a combined "any press or repeat" event.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk          (clk),
      .nrst         (nrst),
      .en           (en),
      .btn_raw      (btn_raw[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign any_press = |(press_pulse | repeat_pulse);

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button traffic,
// compared every cycle against an edge-history reference model.
module tb_btn_conditioner;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk     = 1'b0;
  logic         nrst    = 1'b0;
  logic         en      = 1'b1;
  logic [N-1:0] btn_raw = 4'h0;
  logic [N-1:0] btn_level, press_pulse, release_pulse, repeat_pulse;
  logic         any_press;

  int vectors     = 0;
  int miscompares = 0;
  int obs_rpt2    = 0;
  int obs_ev1     = 0;
  int obs_p1      = 0;

  // model state: raw samples, synchronised samples, debounced level, repeat arming
  logic [N-1:0] rq[$];
  logic [N-1:0] sq[$];
  logic [N-1:0] m_lvl   = 4'h0;
  logic [N-1:0] m_arm   = 4'h0;
  logic [N-1:0] e_press = 4'h0;
  logic [N-1:0] e_rel   = 4'h0;
  logic [N-1:0] e_rpt   = 4'h0;
  int           m_age[N];

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .btn_raw(btn_raw),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .any_press(any_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    sq.delete();
    for (int i = 0; i < SS; i++) rq.push_back(4'h0);
    m_lvl   = 4'h0;
    m_arm   = 4'h0;
    e_press = 4'h0;
    e_rel   = 4'h0;
    e_rpt   = 4'h0;
    for (int c = 0; c < N; c++) m_age[c] = 0;
  endtask

  // A raw sample reaches the debouncer SS edges later; the level flips once
  // the last DB synchronised samples all disagree with it.
  task automatic model_step();
    logic [N-1:0] s, old, rose, fell;
    bit held;
    if (!nrst) begin
      model_reset();
      return;
    end
    rq.push_back(btn_raw);
    s = rq[rq.size() - 1 - SS];
    while (rq.size() > SS) void'(rq.pop_front());
    sq.push_back(s);
    while (sq.size() > DB) void'(sq.pop_front());
    old = m_lvl;
    for (int c = 0; c < N; c++) begin
      held = (sq.size() == DB);
      foreach (sq[k]) if (sq[k][c] == old[c]) held = 1'b0;
      if (held) m_lvl[c] = ~old[c];
    end
    rose    = m_lvl & ~old;
    fell    = ~m_lvl & old;
    e_press = en ? rose : 4'h0;
    e_rel   = en ? fell : 4'h0;
    e_rpt   = 4'h0;
    for (int c = 0; c < N; c++) begin
      if (m_arm[c]) begin
        if (!old[c] || !en) m_arm[c] = 1'b0;
        else begin
          m_age[c]++;
          if (m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0) e_rpt[c] = 1'b1;
        end
      end else if (rose[c] && en && RD > 0) begin
        m_arm[c] = 1'b1;
        m_age[c] = 0;
      end
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("level",   32'(btn_level),     32'(m_lvl));
      chk("press",   32'(press_pulse),   32'(e_press));
      chk("release", 32'(release_pulse), 32'(e_rel));
      chk("repeat",  32'(repeat_pulse),  32'(e_rpt));
      chk("any",     32'(any_press),     32'(|(e_press | e_rpt)));
      obs_rpt2 += int'(repeat_pulse[2]);
      obs_ev1  += int'(press_pulse[1] | repeat_pulse[1]);
      obs_p1   += int'(press_pulse[1]);
    end
  endtask

  task automatic async_reset_check();
    nrst = 1'b0;
    model_reset();
    #1;
    chk("arst_level",   32'(btn_level),     32'h0);
    chk("arst_press",   32'(press_pulse),   32'h0);
    chk("arst_release", 32'(release_pulse), 32'h0);
    chk("arst_repeat",  32'(repeat_pulse),  32'h0);
    chk("arst_any",     32'(any_press),     32'h0);
  endtask

  initial begin
    model_reset();
    btn_raw = 4'hF;
    cyc(3);
    nrst = 1'b1;
    cyc(6);
    chk("rst_lvl",   32'(btn_level),   32'hF);
    chk("rst_press", 32'(press_pulse), 32'hF);
    cyc(1);
    chk("rst_press_once", 32'(press_pulse), 32'h0);
    btn_raw = 4'h0;
    cyc(12);

    // short glitch on channel 0
    btn_raw = 4'b0001;
    cyc(3);
    btn_raw = 4'b0000;
    cyc(10);

    // channel 1 press then release
    obs_p1  = 0;
    btn_raw = 4'b0010;
    cyc(20);
    chk("p1_once", 32'(obs_p1), 32'd1);
    btn_raw = 4'b0000;
    cyc(6);
    chk("rel1", 32'(release_pulse), 32'b0010);
    cyc(8);

    // channel 2 auto-repeat
    obs_rpt2 = 0;
    btn_raw  = 4'b0100;
    cyc(30);
    btn_raw  = 4'b0000;
    cyc(12);
    chk("rpt2_count", 32'(obs_rpt2), 32'd7);

    // enable dropped while repeating, raised while still held
    btn_raw = 4'b0010;
    cyc(20);
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    obs_ev1 = 0;
    cyc(15);
    chk("reen_quiet", 32'(obs_ev1), 32'd0);
    btn_raw = 4'b0000;
    cyc(10);
    obs_p1  = 0;
    btn_raw = 4'b0010;
    cyc(8);
    chk("repress", 32'(obs_p1), 32'd1);
    btn_raw = 4'b0000;
    cyc(10);

    // simultaneous press, then reset in the middle of the delay phase
    btn_raw = 4'b1001;
    cyc(6);
    chk("simul", 32'(press_pulse), 32'b1001);
    cyc(4);
    async_reset_check();
    cyc(2);
    nrst = 1'b1;
    cyc(25);
    btn_raw = 4'b0000;
    cyc(10);

    // random traffic
    for (int it = 0; it < 2500; it++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) btn_raw[b] = ~btn_raw[b];
      if ($urandom_range(0, 79) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
        cyc(2);
        nrst = 1'b1;
      end
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
